// File: rtl/instr_encoder.sv
// instr_encoder: encodes ALU micro-ops into RV32I words and streams them to imem from address 0
// Ports: clk, rst_n (async, active-low), clear (sync flush/restart)
//   in_*   : micro-op valid/ready handshake (op, imm_sel, rd, rs1, rs2, imm, last)
//   imem_* : write request (we/ready handshake) with word address and encoded data
//   err_illegal : 1-cycle pulse after an illegal micro-op is accepted and dropped
//   done / overflow : program fully written / ended because imem capacity ran out
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_imm_sel,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic              done,
  output logic              overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [ADDR_W:0] wr_cnt, reserved, reserved_nx;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] enc;
  logic legal, accept, push, pop, full, empty, ovf_set;
  assign f3 = in_op[1] ? {2'b11, ~in_op[0]} : 3'b000;
  assign f7 = (in_op[1:0] == 2'b01) ? 7'b0100000 : 7'b0000000;
  assign enc = in_imm_sel ? {in_imm, in_rs1, 3'b000, in_rd, 7'b0010011}
                          : {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
  assign legal = !in_op[2] && !(in_imm_sel && |in_op[1:0]);
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  // reserved counts every slot already promised in imem, written or still buffered
  assign reserved = wr_cnt + (ADDR_W+1)'(count);
  assign reserved_nx = reserved + (ADDR_W+1)'(push);
  assign in_ready = (state == RUN) && !clear && !full && (reserved < CAP);
  assign accept = in_valid && in_ready;
  assign push = accept && legal;
  assign imem_we = !empty && (state != DONE);
  assign pop = imem_we && imem_ready;
  // wr_cnt may reach 2**ADDR_W after the final write; the address saturates at max
  assign imem_addr = wr_cnt[ADDR_W] ? '1 : wr_cnt[ADDR_W-1:0];
  assign imem_wdata = mem[rd_ptr];
  assign done = state == DONE;
  assign ovf_set = accept && !in_last && (reserved_nx == CAP);
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN)   ? ((accept && (in_last || reserved_nx == CAP)) ? DRAIN : RUN) :
               (state == DRAIN) ? (empty ? DONE : DRAIN) : DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      wr_cnt <= '0;
      err_illegal <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      state <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      wr_cnt <= '0;
      err_illegal <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) wr_cnt <= wr_cnt + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      err_illegal <= accept && !legal;
      if (ovf_set) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder (ADDR_W=8 and ADDR_W=2 instances)
module tb_instr_encoder;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic a_valid = 0, b_valid = 0, a_clear = 0, b_clear = 0, a_rdy_in = 1, b_rdy_in = 1;
  logic rnd = 0, rbit = 1;
  logic [2:0] op = 0;
  logic sel = 0, last = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [11:0] imm = 0;
  logic a_ready, a_we, a_err, a_done, a_ovf, a_imem;
  logic b_ready, b_we, b_err, b_done, b_ovf;
  logic [7:0] a_addr;
  logic [1:0] b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [40:0] qa[$], qb[$];
  logic [31:0] wlog [16];
  int na = 0, nb = 0, wa = 0, wb = 0, ea = 0, exp_ea = 0;
  int total = 0, passed = 0;
  assign a_imem = a_rdy_in && (!rnd || rbit);

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_valid), .in_ready(a_ready),
    .in_op(op), .in_imm_sel(sel), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
    .in_last(last), .imem_we(a_we), .imem_ready(a_imem), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .err_illegal(a_err), .done(a_done), .overflow(a_ovf));

  instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_valid), .in_ready(b_ready),
    .in_op(op), .in_imm_sel(sel), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
    .in_last(last), .imem_we(b_we), .imem_ready(b_rdy_in), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .err_illegal(b_err), .done(b_done), .overflow(b_ovf));

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference encoding built from field positions with plain arithmetic; bit 32 = legal
  function automatic logic [32:0] ref_enc(int o, int s, int d, int r1, int r2, int im);
    longint w;
    int f3, f7;
    if (o > 3 || (s != 0 && o != 0)) return 33'h0;
    if (s != 0) w = longint'(im) * (1 << 20) + r1 * (1 << 15) + d * (1 << 7) + 19;
    else begin
      f3 = (o == 2) ? 7 : (o == 3) ? 6 : 0;
      f7 = (o == 1) ? 32 : 0;
      w = longint'(f7) * (1 << 25) + r2 * (1 << 20) + r1 * (1 << 15) + f3 * (1 << 12) + d * (1 << 7) + 51;
    end
    return {1'b1, w[31:0]};
  endfunction

  always @(negedge clk) begin
    logic [40:0] e;
    if (rst_n) begin
      if (a_err) ea++;
      if (a_we && a_imem) begin
        wa++;
        if (a_addr < 16) wlog[a_addr[3:0]] = a_wdata;
        check("a_write_expected", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check("a_addr", a_addr, e[40:32]);
          check("a_wdata", a_wdata, e[31:0]);
        end
      end
      if (b_we && b_rdy_in) begin
        wb++;
        check("b_write_expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check("b_addr", b_addr, e[40:32]);
          check("b_wdata", b_wdata, e[31:0]);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rbit = 1'($urandom % 2);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input bit b, input int o, s, d, r1, r2, im, input bit l, input int tries,
                      output bit acc);
    logic [32:0] e;
    op = 3'(o); sel = s[0]; rd = 5'(d); rs1 = 5'(r1); rs2 = 5'(r2); imm = 12'(im); last = l;
    if (b) b_valid = 1; else a_valid = 1;
    acc = 0;
    for (int i = 0; i < tries && !acc; i++) begin
      @(negedge clk);
      if (b ? b_ready : a_ready) begin
        acc = 1;
        e = ref_enc(o, s, d, r1, r2, im);
        if (e[32]) begin
          if (b) begin qb.push_back({9'(nb), e[31:0]}); nb++; end
          else begin qa.push_back({9'(na), e[31:0]}); na++; end
        end else if (!b) exp_ea++;
      end
      @(posedge clk);
      #1;
    end
    a_valid = 0; b_valid = 0; last = 0;
  endtask

  task automatic send_ok(input bit b, input int o, s, d, r1, r2, im, input bit l);
    bit acc;
    send(b, o, s, d, r1, r2, im, l, 40, acc);
    check("accept", acc, 1);
  endtask

  task automatic wait_done(input bit b, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (b ? b_done : a_done) break;
    end
    check("done_reached", b ? b_done : a_done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit b, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!(b ? b_we : a_we)) break;
    end
    check("drained", b ? b_we : a_we, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input bit b);
    if (b) b_clear = 1; else a_clear = 1;
    @(posedge clk);
    #1;
    a_clear = 0; b_clear = 0;
    if (b) begin nb = 0; qb.delete(); end
    else begin na = 0; qa.delete(); end
  endtask

  initial begin
    int o[6], s[6], d[6], r1[6], r2[6], im[6];
    bit acc;
    int cnt, w0, e0;
    logic [31:0] sw;
    repeat (2) @(negedge clk);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 0);
    check("rst_done", a_done, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_err", a_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", a_ready, 1);
    @(posedge clk);
    #1;
    // single ADD, visible the cycle after accept
    send_ok(0, 0, 0, 3, 1, 2, 0, 0);
    @(negedge clk);
    check("t1_we", a_we, 1);
    check("t1_wdata", a_wdata, 32'h002081B3);
    check("t1_addr", a_addr, 0);
    @(posedge clk);
    #1;
    wait_idle(0, 20);
    clr(0);
    // four-instruction program
    w0 = wa;
    send_ok(0, 1, 0, 5, 6, 7, 0, 0);
    send_ok(0, 0, 1, 1, 0, 0, 5, 0);
    send_ok(0, 2, 0, 4, 1, 2, 0, 0);
    send_ok(0, 3, 0, 4, 1, 2, 0, 1);
    wait_done(0, 50);
    check("t2_ovf", a_ovf, 0);
    check("t2_writes", wa - w0, 4);
    check("t2_w0", wlog[0], 32'h407302B3);
    check("t2_w1", wlog[1], 32'h00500093);
    check("t2_w2", wlog[2], 32'h0020F233);
    check("t2_w3", wlog[3], 32'h0020E233);
    clr(0);
    // stalled memory with six offers
    a_rdy_in = 0;
    w0 = wa;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      o[i] = int'($urandom % 4);
      s[i] = (o[i] == 0) ? int'($urandom % 2) : 0;
      d[i] = int'($urandom % 32); r1[i] = int'($urandom % 32);
      r2[i] = int'($urandom % 32); im[i] = int'($urandom % 4096);
      send(0, o[i], s[i], d[i], r1[i], r2[i], im[i], i == 5, 2, acc);
      if (acc) cnt++;
    end
    check("t3_accepted", cnt, 4);
    @(negedge clk);
    check("t3_ready_low", a_ready, 0);
    check("t3_we", a_we, 1);
    check("t3_addr", a_addr, 0);
    sw = a_wdata;
    check("t3_head", sw, qa[0][31:0]);
    repeat (3) @(negedge clk);
    check("t3_stable_data", a_wdata, sw);
    check("t3_stable_addr", a_addr, 0);
    check("t3_no_write", wa, w0);
    @(posedge clk);
    #1;
    a_rdy_in = 1;
    for (int i = 4; i < 6; i++) send_ok(0, o[i], s[i], d[i], r1[i], r2[i], im[i], i == 5);
    wait_done(0, 50);
    check("t3_writes", wa - w0, 6);
    check("t3_queue_empty", qa.size(), 0);
    clr(0);
    // illegal ops
    e0 = ea;
    w0 = wa;
    send_ok(0, 5, 0, 1, 2, 3, 0, 0);
    send_ok(0, 1, 1, 1, 2, 3, 7, 1);
    wait_done(0, 20);
    check("t4_err_pulses", ea - e0, 2);
    check("t4_no_write", wa, w0);
    check("t4_addr", a_addr, 0);
    clr(0);
    // capacity exhaustion on the small instance
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      send(1, i % 4, 0, i + 1, i, i + 2, 0, 0, 2, acc);
      if (acc) cnt++;
    end
    check("t5_accepted", cnt, 4);
    @(negedge clk);
    check("t5_ready_low", b_ready, 0);
    @(posedge clk);
    #1;
    wait_done(1, 30);
    check("t5_ovf", b_ovf, 1);
    check("t5_writes", wb, 4);
    check("t5_addr_sat", b_addr, 3);
    check("t5_queue_empty", qb.size(), 0);
    clr(1);
    @(negedge clk);
    check("t5_clr_done", b_done, 0);
    check("t5_clr_ovf", b_ovf, 0);
    check("t5_clr_addr", b_addr, 0);
    @(posedge clk);
    #1;
    send_ok(1, 2, 0, 9, 8, 7, 0, 0);
    wait_idle(1, 20);
    check("t5_next_addr", b_addr, 1);
    // async reset with stalled FIFO
    a_rdy_in = 0;
    for (int i = 0; i < 3; i++) send_ok(0, i, 0, i + 1, 2, 3, 0, 0);
    @(negedge clk);
    check("t6_we_before", a_we, 1);
    #2 rst_n = 0;
    #1;
    check("t6_we_reset", a_we, 0);
    check("t6_addr_reset", a_addr, 0);
    qa.delete(); na = 0; qb.delete(); nb = 0;
    w0 = wa;
    @(posedge clk);
    #1;
    rst_n = 1;
    a_rdy_in = 1;
    repeat (2) @(negedge clk);
    check("t6_empty", a_we, 0);
    check("t6_ready", a_ready, 1);
    check("t6_no_write", wa, w0);
    @(posedge clk);
    #1;
    // random program with random memory backpressure
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      int ro, rs;
      ro = ($urandom % 5 == 0) ? int'(4 + $urandom % 4) : int'($urandom % 4);
      rs = ($urandom % 3 == 0) ? 1 : 0;
      send_ok(0, ro, rs, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
              int'($urandom % 4096), i == 39);
      repeat ($urandom % 2) begin @(posedge clk); #1; end
    end
    wait_done(0, 400);
    rnd = 0;
    check("t7_queue_empty", qa.size(), 0);
    check("t7_err_count", ea, exp_ea);
    check("t7_ovf", a_ovf, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
